// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg
//   Parametrised UART receiver. It has a built-in sample-tick divider, a
//   2-flop input synchroniser, 3-sample majority voting and false-start
//   rejection. It flags parity, framing and overrun errors, and it holds one
//   received frame behind a valid/ready handshake.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous, active-low reset
//   rxd        in   asynchronous serial line, idle high
//   rx_data    out  received payload, LSB = first bit on the line
//   rx_valid   out  rx_data and error flags hold an unconsumed frame
//   rx_ready   in   consumer accepts the frame when rx_valid && rx_ready
//   parity_err out  parity mismatch for the held frame
//   frame_err  out  a stop bit voted 0 for the held frame
//   overrun    out  sticky: a frame completed while rx_valid was high
//   busy       out  receiver is inside a frame (not IDLE)
module uart_rx_cfg #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int M     = OVERSAMPLE / 2;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int S_W   = $clog2(OVERSAMPLE);

  if (DIV < 1) begin : g_bad_div
    $error("uart_rx_cfg: CLK_FREQ too low for BAUD * OVERSAMPLE");
  end
  if ((OVERSAMPLE < 8) || (OVERSAMPLE % 2 != 0)) begin : g_bad_os
    $error("uart_rx_cfg: OVERSAMPLE must be even and >= 8");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_bits
    $error("uart_rx_cfg: DATA_BITS must be 5..9");
  end
  if ((PARITY < 0) || (PARITY > 2) || (STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_fmt
    $error("uart_rx_cfg: PARITY must be 0..2 and STOP_BITS 1..2");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state;
  logic                 sync1, rxs;
  logic [CNT_W-1:0]     cnt;
  logic [S_W-1:0]       s;
  logic [3:0]           bit_idx;
  logic                 stop_idx;
  logic                 samp_a, samp_b;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_pend, frm_pend;
  logic                 tick, at_vote, at_end, vote, commit, par_x, par_bad;

  // The synchroniser idles high so that reset is not mistaken for a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxs   <= sync1;
    end
  end

  assign tick    = (state != S_IDLE) && (cnt == CNT_W'(DIV - 1));
  assign at_vote = tick && (s == S_W'(M + 1));
  assign at_end  = tick && (s == S_W'(OVERSAMPLE - 1));
  // Samples at M-1 and M are stored. The third sample is taken live at the M+1 tick.
  assign vote    = (samp_a & samp_b) | (samp_a & rxs) | (samp_b & rxs);
  assign commit  = (state == S_STOP) && at_vote && (stop_idx == 1'(STOP_BITS - 1));
  assign par_x   = (^shreg) ^ vote;
  assign par_bad = (PARITY == 1) ? ~par_x : par_x;
  assign busy    = (state != S_IDLE);

  // Frame state machine. The sample counter restarts at every bit boundary, so
  // each bit is re-centred on the ticks and does not depend on earlier bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      s        <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      samp_a   <= 1'b1;
      samp_b   <= 1'b1;
      shreg    <= '0;
      par_pend <= 1'b0;
      frm_pend <= 1'b0;
    end else begin
      if (state == S_IDLE) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DIV - 1)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      if (tick) begin
        if (s == S_W'(M - 1)) samp_a <= rxs;
        if (s == S_W'(M))     samp_b <= rxs;
        s <= at_end ? '0 : s + S_W'(1);
      end

      case (state)
        S_IDLE: begin
          if (!rxs) begin
            state    <= S_START;
            s        <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            par_pend <= 1'b0;
            frm_pend <= 1'b0;
          end
        end
        S_START: begin
          if (at_vote && vote) begin
            state <= S_IDLE;
            s     <= '0;
          end else if (at_end) begin
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (at_vote) shreg <= {vote, shreg[DATA_BITS-1:1]};
          if (at_end) begin
            if (bit_idx == 4'(DATA_BITS - 1)) begin
              state <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end
        end
        S_PARITY: begin
          if (at_vote) par_pend <= par_bad;
          if (at_end)  state <= S_STOP;
        end
        S_STOP: begin
          // The last stop bit ends the frame at its vote. This leaves half a
          // bit of slack to catch a back-to-back start edge.
          if (at_vote) begin
            if (!vote) frm_pend <= 1'b1;
            if (commit) begin
              state <= S_IDLE;
              s     <= '0;
            end
          end
          if (at_end) stop_idx <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // One-entry output register. A handshake and a commit on the same edge let
  // the new frame replace the accepted one without raising overrun.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end
      if (commit) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shreg;
          parity_err <= par_pend;
          frame_err  <= frm_pend | ~vote;
          rx_valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg
//   Bench for uart_rx_cfg. It runs three instances: 8N1 (lane 0),
//   8E1 (lane 1) and 7O2 (lane 2). All use DIV = 1, so one bit lasts 16 clocks.
//   Accepted frames are captured per lane by a monitor. They are compared
//   with a reference model that counts ones in the frame to find the parity
//   error and inspects the stop-bit levels to find the framing error.
module tb_uart_rx_cfg;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] rxd, rdy, v, pe, fe, ov, bz;
  logic [7:0] d0, d1;
  logic [6:0] d2;

  int checks   = 0;
  int failures = 0;

  int lane_dbits [3] = '{8, 8, 7};
  int lane_par   [3] = '{0, 2, 1};
  int lane_stop  [3] = '{1, 1, 2};

  int         got_n   [3] = '{0, 0, 0};
  int         vhigh_n [3] = '{0, 0, 0};
  logic [8:0] got_d   [3];
  logic       got_pe  [3];
  logic       got_fe  [3];

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLK_FREQ(16000000), .BAUD(1000000), .OVERSAMPLE(16),
                .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .rxd(rxd[0]), .rx_data(d0), .rx_valid(v[0]),
    .rx_ready(rdy[0]), .parity_err(pe[0]), .frame_err(fe[0]),
    .overrun(ov[0]), .busy(bz[0]));

  uart_rx_cfg #(.CLK_FREQ(16000000), .BAUD(1000000), .OVERSAMPLE(16),
                .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst), .rxd(rxd[1]), .rx_data(d1), .rx_valid(v[1]),
    .rx_ready(rdy[1]), .parity_err(pe[1]), .frame_err(fe[1]),
    .overrun(ov[1]), .busy(bz[1]));

  uart_rx_cfg #(.CLK_FREQ(16000000), .BAUD(1000000), .OVERSAMPLE(16),
                .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_7o2 (
    .clk(clk), .rst(rst), .rxd(rxd[2]), .rx_data(d2), .rx_valid(v[2]),
    .rx_ready(rdy[2]), .parity_err(pe[2]), .frame_err(fe[2]),
    .overrun(ov[2]), .busy(bz[2]));

  function automatic logic [8:0] dat(input int lane);
    case (lane)
      0:       return {1'b0, d0};
      1:       return {1'b0, d1};
      default: return {2'b00, d2};
    endcase
  endfunction

  // Capture every frame the consumer takes, at the cycle before the handshake edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (v[i]) vhigh_n[i]++;
      if (v[i] && rdy[i]) begin
        got_n[i]++;
        got_d[i]  = dat(i);
        got_pe[i] = pe[i];
        got_fe[i] = fe[i];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference model: the payload is masked to the lane width. The parity error
  // follows from the count of ones (payload plus parity bit). The framing error
  // is set by any stop bit that is low.
  task automatic model(input int lane, input logic [8:0] data, input logic pbit,
                       input logic [1:0] stops, output logic [8:0] ed,
                       output logic epe, output logic efe);
    int ones = 0;
    ed = data & ((9'h1 << lane_dbits[lane]) - 9'h1);
    for (int i = 0; i < lane_dbits[lane]; i++) ones += int'(data[i]);
    ones += int'(pbit);
    case (lane_par[lane])
      1:       epe = (ones % 2) == 0;
      2:       epe = (ones % 2) == 1;
      default: epe = 1'b0;
    endcase
    efe = !stops[0] || (lane_stop[lane] == 2 && !stops[1]);
  endtask

  task automatic send_frame(input int lane, input logic [8:0] data, input logic pbit,
                            input logic [1:0] stops);
    logic [12:0] bits = '1;
    int n = 0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < lane_dbits[lane]; i++) begin bits[n] = data[i]; n++; end
    if (lane_par[lane] != 0) begin bits[n] = pbit; n++; end
    for (int i = 0; i < lane_stop[lane]; i++) begin bits[n] = stops[i]; n++; end
    for (int b = 0; b < n; b++) begin
      rxd[lane] = bits[b];
      repeat (16) @(negedge clk);
    end
    rxd[lane] = 1'b1;
  endtask

  task automatic apply_stimulus(input int lane, input logic [8:0] data, input logic pbit,
                                input logic [1:0] stops);
    send_frame(lane, data, pbit, stops);
    repeat (20) @(negedge clk);
  endtask

  task automatic check_output(input string name, input int lane, input int n_before,
                              input logic [8:0] ed, input logic epe, input logic efe);
    check({name, ".count"}, 32'(got_n[lane] - n_before), 32'd1);
    check({name, ".data"},  32'(got_d[lane]), 32'(ed));
    check({name, ".perr"},  32'(got_pe[lane]), 32'(epe));
    check({name, ".ferr"},  32'(got_fe[lane]), 32'(efe));
  endtask

  typedef struct {
    string      name;
    int         lane;
    logic [8:0] data;
    logic       pbit;
    logic [1:0] stops;
    logic [8:0] exp_d;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  initial begin
    vec_t       vecs [6];
    int         n0, v0, lat;
    logic [8:0] ed, rdata;
    logic       epe, efe, rpbit;
    logic [1:0] rstops;
    int         rlane;

    vecs[0] = '{name:"8n1_a5",      lane:0, data:9'h0A5, pbit:1'b0, stops:2'b11, exp_d:9'h0A5, exp_pe:1'b0, exp_fe:1'b0};
    vecs[1] = '{name:"8e1_3c_bad",  lane:1, data:9'h03C, pbit:1'b1, stops:2'b11, exp_d:9'h03C, exp_pe:1'b1, exp_fe:1'b0};
    vecs[2] = '{name:"8e1_3c_good", lane:1, data:9'h03C, pbit:1'b0, stops:2'b11, exp_d:9'h03C, exp_pe:1'b0, exp_fe:1'b0};
    vecs[3] = '{name:"7o2_55_stop2",lane:2, data:9'h055, pbit:1'b1, stops:2'b01, exp_d:9'h055, exp_pe:1'b0, exp_fe:1'b1};
    vecs[4] = '{name:"8n1_stop0",   lane:0, data:9'h000, pbit:1'b0, stops:2'b10, exp_d:9'h000, exp_pe:1'b0, exp_fe:1'b1};
    vecs[5] = '{name:"7o2_7f_odd",  lane:2, data:9'h07F, pbit:1'b0, stops:2'b11, exp_d:9'h07F, exp_pe:1'b0, exp_fe:1'b0};

    rxd = 3'b111;
    rdy = 3'b111;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_outputs_lane%0d", i),
            32'({dat(i), v[i], pe[i], fe[i], ov[i], bz[i]}), 32'd0);
    end
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Frame latency and single-cycle rx_valid with rx_ready held high.
    // The nominal latency is 9.5 bit periods plus about 3 clocks of pipeline, so 155 clocks.
    n0 = got_n[0];
    v0 = vhigh_n[0];
    lat = 0;
    fork
      send_frame(0, 9'h0A5, 1'b0, 2'b11);
      begin
        while (lat < 400) begin
          @(negedge clk);
          lat++;
          if (v[0]) break;
        end
      end
    join
    repeat (20) @(negedge clk);
    checks++;
    if (lat < 152 || lat > 158) begin
      failures++;
      $display("[TB] FAIL latency got=%0d expected=152..158", lat);
    end
    check("valid_one_cycle", 32'(vhigh_n[0] - v0), 32'd1);
    check_output("latency_frame", 0, n0, 9'h0A5, 1'b0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      n0 = got_n[vecs[k].lane];
      apply_stimulus(vecs[k].lane, vecs[k].data, vecs[k].pbit, vecs[k].stops);
      check_output(vecs[k].name, vecs[k].lane, n0, vecs[k].exp_d, vecs[k].exp_pe, vecs[k].exp_fe);
    end

    for (int k = 0; k < 30; k++) begin
      rlane  = int'($urandom_range(0, 2));
      rdata  = 9'($urandom);
      rpbit  = 1'($urandom);
      rstops = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      model(rlane, rdata, rpbit, rstops, ed, epe, efe);
      n0 = got_n[rlane];
      apply_stimulus(rlane, rdata, rpbit, rstops);
      check_output($sformatf("rand%0d_lane%0d", k, rlane), rlane, n0, ed, epe, efe);
    end

    // Overrun: two back-to-back frames with the consumer stalled.
    @(posedge clk); #2 rdy[0] = 1'b0;
    @(negedge clk);
    n0 = got_n[0];
    send_frame(0, 9'h011, 1'b0, 2'b11);
    send_frame(0, 9'h022, 1'b0, 2'b11);
    repeat (10) @(negedge clk);
    check("ovr_valid", 32'(v[0]), 32'd1);
    check("ovr_data_held", 32'(dat(0)), 32'h11);
    check("ovr_flag", 32'(ov[0]), 32'd1);
    @(posedge clk); #2 rdy[0] = 1'b1;
    @(posedge clk); #2 rdy[0] = 1'b0;
    @(negedge clk);
    check("ovr_accept_valid", 32'(v[0]), 32'd0);
    check("ovr_accept_flag", 32'(ov[0]), 32'd0);
    check("ovr_accepted_data", 32'(got_d[0]), 32'h11);
    check("ovr_accept_count", 32'(got_n[0] - n0), 32'd1);
    @(posedge clk); #2 rdy[0] = 1'b1;
    @(negedge clk);

    // Glitch shorter than the vote window, then a real frame.
    n0 = got_n[0];
    rxd[0] = 1'b0;
    repeat (5) @(negedge clk);
    rxd[0] = 1'b1;
    repeat (11) @(negedge clk);
    check("glitch_busy_low", 32'(bz[0]), 32'd0);
    check("glitch_no_output", 32'(got_n[0] - n0), 32'd0);
    repeat (8) @(negedge clk);
    apply_stimulus(0, 9'h080, 1'b0, 2'b11);
    check_output("after_glitch", 0, n0, 9'h080, 1'b0, 1'b0);

    // Reset during data bit 3 of 0xFF.
    n0 = got_n[0];
    rxd[0] = 1'b0;
    repeat (16) @(negedge clk);
    rxd[0] = 1'b1;
    repeat (3 * 16 + 8) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("midframe_reset_lane%0d", i),
            32'({dat(i), v[i], pe[i], fe[i], ov[i], bz[i]}), 32'd0);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (128) @(negedge clk);
    check("no_partial_frame", 32'(got_n[0] - n0), 32'd0);
    check("no_partial_valid", 32'(v[0]), 32'd0);
    apply_stimulus(0, 9'h042, 1'b0, 2'b11);
    check_output("after_reset", 0, n0, 9'h042, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
